// File: rtl/host_cmd_engine.sv
// Host command engine: executes host register/memory commands one at a time
// and returns status-tagged responses on a valid/ready channel.
module host_cmd_engine #(
  parameter int NUM_REGS     = 6,
  parameter int REG_WORDS    = 2,
  parameter int NUM_MEMS     = 1,
  parameter int MEM_WORDS    = 1,
  parameter int ADDR_W       = 32,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             cmd_valid,
  output logic                                             cmd_ready,
  input  logic [31:0]                                      cmd_opcode,
  input  logic [31:0]                                      cmd_id,
  input  logic [31:0]                                      cmd_mask,
  input  logic [ADDR_W-1:0]                                cmd_addr,
  input  logic [31:0]                                      cmd_data,
  input  logic [15:0]                                      cmd_len,
  output logic                                             rsp_valid,
  input  logic                                             rsp_ready,
  output logic [31:0]                                      rsp_data,
  output logic [1:0]                                       rsp_status,
  output logic                                             rsp_last,
  output logic                                             reg_wr,
  output logic                                             reg_rd,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0]   reg_id,
  output logic [((REG_WORDS > 1) ? $clog2(REG_WORDS) : 1)-1:0] reg_word,
  output logic [31:0]                                      reg_wdata,
  input  logic [31:0]                                      reg_rdata,
  output logic                                             mem_req_valid,
  input  logic                                             mem_req_ready,
  output logic [((NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1)-1:0]   mem_id,
  output logic                                             mem_we,
  output logic [ADDR_W-1:0]                                mem_addr,
  output logic [MEM_WORDS-1:0]                             mem_wstrb,
  output logic [32*MEM_WORDS-1:0]                          mem_wdata,
  input  logic                                             mem_rsp_valid,
  input  logic [32*MEM_WORDS-1:0]                          mem_rdata
);

  localparam int RID_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int RWD_W  = (REG_WORDS > 1) ? $clog2(REG_WORDS) : 1;
  localparam int MID_W  = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
  localparam int LANE_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, REG_RD, MEM_REQ, MEM_WAIT, POLL_RD, POLL_CHK, RESP} state_e;
  typedef enum logic [1:0] {ST_OK, ST_BAD_OPCODE, ST_BAD_ID_MASK, ST_TIMEOUT} status_e;

  state_e                  state_q;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q, rsp_last_q;
  logic [31:0]             rsp_data_q;
  status_e                 rsp_status_q;
  logic                    reg_wr_q, reg_rd_q;
  logic [RID_W-1:0]        reg_id_q;
  logic [RWD_W-1:0]        reg_word_q;
  logic [31:0]             reg_wdata_q;
  logic                    mem_req_valid_q, mem_we_q;
  logic [MID_W-1:0]        mem_id_q;
  logic [ADDR_W-1:0]       mem_addr_q;
  logic [MEM_WORDS-1:0]    mem_wstrb_q;
  logic [32*MEM_WORDS-1:0] mem_wdata_q;
  logic                    is_burst_q;
  logic [31:0]             data_q;
  logic [LANE_W-1:0]       lane_q;
  logic [15:0]             beats_q;
  logic [31:0]             poll_cnt_q;

  logic        accept;
  logic        reg_ok, mem_ok;
  logic        op_wr_reg, op_rd_reg, op_wr_mem;
  state_e      dec_state_d;
  status_e     dec_status_d;
  logic [31:0] dec_data_d;
  logic [31:0] lane_data_d;

  assign accept    = cmd_valid && cmd_ready_q;
  assign reg_ok    = (cmd_id < 32'(NUM_REGS)) && (cmd_mask < 32'(REG_WORDS));
  assign mem_ok    = (cmd_id < 32'(NUM_MEMS)) && (cmd_mask < 32'(MEM_WORDS));
  assign op_wr_reg = (cmd_opcode == 32'd1);
  assign op_rd_reg = (cmd_opcode == 32'd2);
  assign op_wr_mem = (cmd_opcode == 32'd3);

  // Decode of the presented command, consumed only in the acceptance cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec_state_d  = RESP;
    dec_status_d = ST_OK;
    dec_data_d   = '0;
    case (cmd_opcode)
      32'd0:               dec_data_d = 32'hdeadbeef;
      32'd1, 32'd2:        if (reg_ok) dec_state_d = REG_RD;  else dec_status_d = ST_BAD_ID_MASK;
      32'd3, 32'd4, 32'd5: if (mem_ok) dec_state_d = MEM_REQ; else dec_status_d = ST_BAD_ID_MASK;
      32'd6:               if (reg_ok) dec_state_d = POLL_RD; else dec_status_d = ST_BAD_ID_MASK;
      default:             dec_status_d = ST_BAD_OPCODE;
    endcase
  end

  always_comb begin
    lane_data_d = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (lane_q == LANE_W'(i)) lane_data_d = mem_rdata[i*32 +: 32];
    end
  end

  // NOTE: state and every registered output update with non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_last_q      <= 1'b0;
      rsp_data_q      <= '0;
      rsp_status_q    <= ST_OK;
      reg_wr_q        <= 1'b0;
      reg_rd_q        <= 1'b0;
      reg_id_q        <= '0;
      reg_word_q      <= '0;
      reg_wdata_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_id_q        <= '0;
      mem_addr_q      <= '0;
      mem_wstrb_q     <= '0;
      mem_wdata_q     <= '0;
      is_burst_q      <= 1'b0;
      data_q          <= '0;
      lane_q          <= '0;
      beats_q         <= '0;
      poll_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= !accept;
          if (accept) begin
            state_q         <= dec_state_d;
            rsp_valid_q     <= (dec_state_d == RESP);
            rsp_data_q      <= dec_data_d;
            rsp_status_q    <= dec_status_d;
            rsp_last_q      <= 1'b1;
            is_burst_q      <= (cmd_opcode == 32'd5);
            data_q          <= cmd_data;
            lane_q          <= cmd_mask[LANE_W-1:0];
            beats_q         <= (cmd_len == 16'd0) ? 16'd1 : cmd_len;
            poll_cnt_q      <= '0;
            reg_id_q        <= cmd_id[RID_W-1:0];
            reg_word_q      <= cmd_mask[RWD_W-1:0];
            reg_wdata_q     <= cmd_data;
            reg_wr_q        <= (dec_state_d == REG_RD) && op_wr_reg;
            reg_rd_q        <= ((dec_state_d == REG_RD) && op_rd_reg) || (dec_state_d == POLL_RD);
            mem_id_q        <= cmd_id[MID_W-1:0];
            mem_addr_q      <= cmd_addr;
            mem_wdata_q     <= {MEM_WORDS{cmd_data}};
            mem_req_valid_q <= (dec_state_d == MEM_REQ);
            mem_we_q        <= (dec_state_d == MEM_REQ) && op_wr_mem;
            mem_wstrb_q     <= ((dec_state_d == MEM_REQ) && op_wr_mem) ?
                               (MEM_WORDS'(1) << cmd_mask[LANE_W-1:0]) : '0;
          end
        end
        // Strobe cycle for writes and reads; a read then waits one cycle for reg_rdata.
        REG_RD: begin
          if (reg_wr_q) begin
            reg_wr_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (reg_rd_q) begin
            reg_rd_q <= 1'b0;
          end else begin
            rsp_data_q  <= reg_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_wstrb_q     <= '0;
            if (mem_we_q) begin
              rsp_data_q  <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_data_q  <= lane_data_d;
            rsp_last_q  <= !is_burst_q || (beats_q == 16'd1);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        POLL_RD: begin
          reg_rd_q <= 1'b0;
          state_q  <= POLL_CHK;
        end
        POLL_CHK: begin
          poll_cnt_q <= poll_cnt_q + 32'd1;
          rsp_data_q <= reg_rdata;
          if (reg_rdata == data_q) begin
            rsp_status_q <= ST_OK;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (poll_cnt_q == 32'(POLL_TIMEOUT - 1)) begin
            rsp_status_q <= ST_TIMEOUT;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            reg_rd_q <= 1'b1;
            state_q  <= POLL_RD;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (is_burst_q && !rsp_last_q) begin
              beats_q         <= beats_q - 16'd1;
              mem_addr_q      <= mem_addr_q + ADDR_W'(1);
              mem_req_valid_q <= 1'b1;
              state_q         <= MEM_REQ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_last      = rsp_last_q;
  assign reg_wr        = reg_wr_q;
  assign reg_rd        = reg_rd_q;
  assign reg_id        = reg_id_q;
  assign reg_word      = reg_word_q;
  assign reg_wdata     = reg_wdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_id        = mem_id_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_host_cmd_engine.sv
// Directed bench for host_cmd_engine with a small register file and memory model.
module tb_host_cmd_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_opcode = '0, cmd_id = '0, cmd_mask = '0, cmd_addr = '0, cmd_data = '0;
  logic [15:0] cmd_len = '0;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        reg_wr, reg_rd;
  logic [2:0]  reg_id;
  logic [0:0]  reg_word;
  logic [31:0] reg_wdata, reg_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b1, mem_we, mem_rsp_valid;
  logic [0:0]  mem_id, mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  host_cmd_engine #(.POLL_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_id(cmd_id),
    .cmd_mask(cmd_mask), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .rsp_last(rsp_last),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_id(reg_id), .reg_word(reg_word),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_id(mem_id), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Response ready: constant 1, or alternating each cycle while toggling is enabled.
  logic rsp_toggle = 1'b0;
  logic rsp_phase  = 1'b0;
  always @(negedge clock) rsp_phase <= ~rsp_phase;
  assign rsp_ready = rsp_toggle ? rsp_phase : 1'b1;

  // Register file model: read data valid exactly one cycle after reg_rd.
  logic [31:0] regs [0:5][0:1];
  int          rd_cnt = 0, wr_cnt = 0, rd_base = 0, poll_match_at = 0;
  logic        poll_mode = 1'b0;
  logic [35:0] last_wr = '0;
  always @(posedge clock) begin
    if (reg_wr) begin
      regs[reg_id][reg_word] <= reg_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wr <= {reg_id, reg_word, reg_wdata};
    end
    if (reg_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (poll_mode)
        reg_rdata <= (poll_match_at != 0 && (rd_cnt - rd_base + 1) >= poll_match_at) ? 32'd1 : 32'd0;
      else
        reg_rdata <= regs[reg_id][reg_word];
    end else begin
      reg_rdata <= 'x;
    end
  end

  // Memory model: one-cycle read latency; unwritten words read as 0xB0000000|addr.
  logic [31:0] mem_store   [0:255];
  bit          mem_written [0:255];
  logic        mem_mute = 1'b0;
  int          req_cnt = 0, overlap = 0;
  logic [31:0] req_addr_q [$];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_rsp_valid <= 1'b0;
      mem_rdata     <= '0;
    end else begin
      mem_rsp_valid <= 1'b0;
      if (mem_req_valid && rsp_valid) overlap <= overlap + 1;
      if (mem_req_valid && mem_req_ready) begin
        req_cnt <= req_cnt + 1;
        req_addr_q.push_back(mem_addr);
        if (mem_we) begin
          if (mem_wstrb[0]) begin
            mem_store[mem_addr[7:0]]   <= mem_wdata;
            mem_written[mem_addr[7:0]] <= 1'b1;
          end
        end else if (!mem_mute) begin
          mem_rsp_valid <= 1'b1;
          mem_rdata     <= mem_written[mem_addr[7:0]] ? mem_store[mem_addr[7:0]]
                                                      : (32'hB000_0000 | mem_addr);
        end
      end
    end
  end

  typedef struct packed {logic [31:0] data; logic [1:0] status; logic last;} rsp_t;
  rsp_t rsp_q [$];
  always @(posedge clock) if (reset && rsp_valid && rsp_ready) rsp_q.push_back({rsp_data, rsp_status, rsp_last});

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input string tag, input logic [31:0] op, input logic [31:0] id,
                          input logic [31:0] mask, input logic [31:0] addr,
                          input logic [31:0] data, input logic [15:0] len);
    int n = 0;
    cmd_opcode = op; cmd_id = id; cmd_mask = mask; cmd_addr = addr; cmd_data = data; cmd_len = len;
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clock); n++; end
    check({tag, "_accept"}, cmd_ready, 1'b1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] d, input logic [1:0] s, input logic l);
    int   n = 0;
    rsp_t r;
    while (rsp_q.size() == 0 && n < 200) begin @(negedge clock); n++; end
    check({tag, "_present"}, (rsp_q.size() > 0), 1'b1);
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      check({tag, "_rsp"}, r, {d, s, l});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          base_rd, base_wr, base_req;
    logic [31:0] a;

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_outputs", {cmd_ready, rsp_valid, reg_wr, reg_rd, mem_req_valid, rsp_data}, '0);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", cmd_ready, 1'b1);

    // nop: one response, cmd_ready low for exactly two cycles
    send_cmd("nop", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0);
    cnt = 0;
    while (!cmd_ready && cnt < 20) begin cnt++; @(negedge clock); end
    check("nop_ready_low_cycles", cnt, 2);
    expect_rsp("nop", 32'hdeadbeef, 2'd0, 1'b1);

    // Register write then read back
    base_wr = wr_cnt;
    send_cmd("wr_reg", 32'd1, 32'd2, 32'd1, 32'd0, 32'h12345678, 16'd0);
    expect_rsp("wr_reg", 32'd0, 2'd0, 1'b1);
    check("wr_reg_pulses", wr_cnt - base_wr, 1);
    check("wr_reg_target", last_wr, {3'd2, 1'b1, 32'h12345678});
    send_cmd("rd_reg", 32'd2, 32'd2, 32'd1, 32'd0, 32'd0, 16'd0);
    expect_rsp("rd_reg", 32'h12345678, 2'd0, 1'b1);

    // Memory write with mem_req_ready low for three cycles
    mem_req_ready = 1'b0;
    send_cmd("wr_mem", 32'd3, 32'd0, 32'd0, 32'h10, 32'hCAFEF00D, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check("wr_mem_req_stable", {mem_req_valid, mem_we, mem_wstrb, mem_id, mem_addr, mem_wdata},
            {1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFEF00D});
      if (i == 3) mem_req_ready = 1'b1;
      @(negedge clock);
    end
    expect_rsp("wr_mem", 32'd0, 2'd0, 1'b1);
    send_cmd("rd_mem", 32'd4, 32'd0, 32'd0, 32'h10, 32'd0, 16'd0);
    expect_rsp("rd_mem", 32'hCAFEF00D, 2'd0, 1'b1);

    // Burst of four with rsp_ready toggling
    req_addr_q.delete();
    overlap    = 0;
    rsp_toggle = 1'b1;
    send_cmd("burst4", 32'd5, 32'd0, 32'd0, 32'h20, 32'd0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      a = 32'h20 + i;
      expect_rsp("burst4_beat", 32'hB000_0000 | a, 2'd0, (i == 3));
    end
    rsp_toggle = 1'b0;
    check("burst4_req_count", req_addr_q.size(), 4);
    for (int i = 0; i < 4 && req_addr_q.size() > 0; i++) begin
      a = 32'h20 + i;
      check("burst4_req_addr", req_addr_q.pop_front(), a);
    end
    check("burst4_no_overlap", overlap, 0);

    // Burst with length 0 behaves as length 1
    base_req = req_cnt;
    send_cmd("burst0", 32'd5, 32'd0, 32'd0, 32'h40, 32'd0, 16'd0);
    expect_rsp("burst0", 32'hB000_0040, 2'd0, 1'b1);
    repeat (3) @(negedge clock);
    check("burst0_req_count", req_cnt - base_req, 1);
    check("burst0_single_rsp", rsp_q.size(), 0);

    // Poll that matches on the fifth read
    poll_mode = 1'b1; poll_match_at = 5; rd_base = rd_cnt; base_rd = rd_cnt;
    send_cmd("poll_ok", 32'd6, 32'd3, 32'd0, 32'd0, 32'd1, 16'd0);
    expect_rsp("poll_ok", 32'd1, 2'd0, 1'b1);
    check("poll_ok_reads", rd_cnt - base_rd, 5);

    // Poll that never matches: timeout after POLL_TIMEOUT reads
    poll_match_at = 0; rd_base = rd_cnt; base_rd = rd_cnt;
    send_cmd("poll_to", 32'd6, 32'd3, 32'd0, 32'd0, 32'd1, 16'd0);
    expect_rsp("poll_to", 32'd0, 2'd3, 1'b1);
    check("poll_to_reads", rd_cnt - base_rd, 8);
    poll_mode = 1'b0;

    // Bad opcode and bad register id: no strobes
    base_rd = rd_cnt; base_wr = wr_cnt; base_req = req_cnt;
    send_cmd("bad_op", 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0);
    expect_rsp("bad_op", 32'd0, 2'd1, 1'b1);
    send_cmd("bad_id", 32'd2, 32'd6, 32'd1, 32'd0, 32'd0, 16'd0);
    cnt = 0;
    while (rsp_q.size() == 0 && cnt < 50) begin @(negedge clock); cnt++; end
    check("bad_id_present", (rsp_q.size() > 0), 1'b1);
    if (rsp_q.size() > 0) check("bad_id_status_last", rsp_q.pop_front() & 35'h7, {2'd2, 1'b1});
    check("bad_cmds_no_strobes", {rd_cnt - base_rd, wr_cnt - base_wr, req_cnt - base_req}, '0);

    // Reset while waiting on memory read data: command abandoned
    mem_mute = 1'b1;
    send_cmd("abandon", 32'd4, 32'd0, 32'd0, 32'h10, 32'd0, 16'd0);
    repeat (2) @(negedge clock);
    check("abandon_in_wait", {mem_req_valid, rsp_valid}, 2'b00);
    reset = 1'b0;
    #1;
    check("abandon_reset_outputs", {cmd_ready, rsp_valid, mem_req_valid, reg_rd, reg_wr}, '0);
    @(negedge clock);
    reset    = 1'b1;
    mem_mute = 1'b0;
    @(negedge clock);
    check("abandon_ready_after", cmd_ready, 1'b1);
    repeat (5) @(negedge clock);
    check("abandon_no_rsp", rsp_q.size(), 0);
    send_cmd("after_reset_rd", 32'd4, 32'd0, 32'd0, 32'h10, 32'd0, 16'd0);
    expect_rsp("after_reset_rd", 32'hCAFEF00D, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
